// File: rtl/shift_sub_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider_pkg
// Brief    : Shared types and constants for the restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
package shift_sub_divider_pkg;

    localparam int DEFAULT_N = 5;
    localparam int RESULT_W  = 2 * DEFAULT_N;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_D  = 3'd1,
        LD_H  = 3'd2,
        LD_L  = 3'd3,
        CHECK = 3'd4,
        DIV   = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_sub_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider_if
// Brief    : Operand/result bus between a requester and the divider.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_sub_divider_if #(
    parameter int N = shift_sub_divider_pkg::DEFAULT_N
);
    logic           start;
    logic [N-1:0]   inbus;
    logic           busy;
    logic           done;
    logic           err;
    logic [2*N-1:0] result;

    modport master (
        output start, inbus,
        input  busy, done, err, result
    );

    modport slave (
        input  start, inbus,
        output busy, done, err, result
    );
endinterface
`default_nettype wire

// File: rtl/shift_sub_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider_div_step
// Brief    : Combinational trial subtraction for one restoring-division step.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sub_divider_div_step
    import shift_sub_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  wire logic [N:0]   i_trial,
    input  wire logic [N-1:0] i_divisor,
    output logic      [N-1:0] o_rem,
    output logic              o_q_bit
);

    logic         w_fits;
    logic [N-1:0] w_diff;

    // Remainder stays below the divisor, so the difference always fits in N
    // bits and modulo-2^N subtraction of the low bits gives it exactly.
    assign w_fits  = (i_trial >= {1'b0, i_divisor});
    assign w_diff  = i_trial[N-1:0] - i_divisor;
    assign o_rem   = w_fits ? w_diff : i_trial[N-1:0];
    assign o_q_bit = w_fits;

endmodule
`default_nettype wire

// File: rtl/shift_sub_divider.sv
`default_nettype none
// ============================================================================
// Module   : shift_sub_divider
// Brief    : Sequential unsigned restoring divider, 2N/N -> {rem, quo}.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input wire logic          clk,
    input wire logic          rst,
    shift_sub_divider_if.slave bus
);

    localparam int                 C_CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(N - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [N-1:0]         r_divisor;
    logic [N-1:0]         r_rem;
    logic [N-1:0]         r_quo;
    logic [C_CNT_W-1:0]   r_count;
    logic [2*N-1:0]       r_result;
    logic                 r_err;

    logic [N-1:0]         w_step_rem;
    logic                 w_step_q;
    logic [N-1:0]         w_quo_next;
    logic                 w_check_err;
    logic                 w_last;

    shift_sub_divider_div_step #(.N(N)) u_step (
        .i_trial   ({r_rem, r_quo[N-1]}),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    assign w_quo_next = {r_quo[N-2:0], w_step_q};
    // A high half at or above the divisor means the quotient needs > N bits.
    assign w_check_err = (r_divisor == '0) || (r_rem >= r_divisor);
    assign w_last      = (r_count == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = LD_D;
            LD_D:    w_state_next = LD_H;
            LD_H:    w_state_next = LD_L;
            LD_L:    w_state_next = CHECK;
            CHECK:   w_state_next = w_check_err ? DONE : DIV;
            DIV:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) r_err <= 1'b0;
                LD_D: r_divisor <= bus.inbus;
                LD_H: r_rem     <= bus.inbus;
                LD_L: r_quo     <= bus.inbus;
                CHECK: begin
                    if (w_check_err) begin
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_count  <= '0;
                    end
                end
                DIV: begin
                    r_rem   <= w_step_rem;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) r_result <= {w_step_rem, w_quo_next};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.done   = (r_state == DONE);
    assign bus.err    = r_err;
    assign bus.result = r_result;

endmodule
`default_nettype wire
